avalon_bridge: RTL and testbench

AVALON_BRIDGE -- requirements
Module: avalon_bridge

---
 rtl/avalon_bridge.sv | 144 ++++++++++++++
 tb/tb_avalon_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_bridge.sv
// avalon_bridge: bridges a simple CPU request/done bus onto an Avalon-MM master.
// One transaction at a time. The bridge registers the CPU request in IDLE.
// It then holds read or write in RD/WR until the slave drops wait_request.
// After that it pulses Done for one cycle and returns to IDLE.
// Addresses up to MEM_END_WORD_ADDR are memory words and are scaled by
// BYTE_PER_WORD. Addresses above it form an unscaled I/O window.
// Optional feature: define AVALON_BRIDGE_TIMEOUT_EN to abort a transaction
// (Done with Err) after TIMEOUT_CYC wait-request cycles.
//
// Handshake: the bridge asserts avalon_read/avalon_write and holds address,
// writedata and byteenable steady. The transfer completes on the first rising
// edge where avalon_wait_request is 0.
module avalon_bridge #(
    parameter int          DATA_W            = 16,
    parameter int          ADDR_W            = 16,
    parameter int unsigned MEM_END_WORD_ADDR = 16'h80,
    parameter int unsigned BYTE_PER_WORD     = 4,
    parameter int unsigned TIMEOUT_CYC       = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              W,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DOUT,
    output logic [DATA_W-1:0] DIN,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    input  logic              avalon_wait_request,
    input  logic [31:0]       avalon_readdata,
    output logic              avalon_read,
    output logic              avalon_write,
    output logic [31:0]       avalon_address,
    output logic [31:0]       avalon_writedata,
    output logic [3:0]        avalon_byteenable,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         BE_N    = (DATA_W + 7) / 8;
    localparam logic [4:0] BE_MASK = 5'((1 << BE_N) - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic [31:0]       addr32;
    logic              mem_hit;
    logic              accept;
    logic              in_xfer;
    logic              timeout_hit;

    assign accept  = (state == IDLE) && Req;
    assign in_xfer = (state == RD) || (state == WR);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: slave completion or timeout abort both go through DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Req) state_nxt = W ? WR : RD;
            RD:   if (!avalon_wait_request || timeout_hit) state_nxt = DONE;
            WR:   if (!avalon_wait_request || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the CPU request on accept; load read data on a completed read
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q <= '0;
            dout_q <= '0;
            DIN    <= '0;
        end else begin
            if (accept) begin
                addr_q <= ADDR;
                dout_q <= DOUT;
            end
            if ((state == RD) && !avalon_wait_request)
                DIN <= avalon_readdata[DATA_W-1:0];
        end
    end

`ifdef AVALON_BRIDGE_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        err_q;

    assign timeout_hit = in_xfer && avalon_wait_request &&
                         (to_cnt == (32'(TIMEOUT_CYC) - 32'd1));
    assign Err = err_q;

    // Wait-cycle counter and sticky abort flag (cleared by the next accepted Req)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                to_cnt <= '0;
                err_q  <= 1'b0;
            end else if (in_xfer && avalon_wait_request) begin
                to_cnt <= to_cnt + 32'd1;
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
    assign Err            = 1'b0;
`endif

    // The upper read-data bits beyond DATA_W are intentionally dropped
    logic unused_rdata;
    assign unused_rdata = &{1'b0, avalon_readdata};

    // Memory window scales word addresses to bytes; the I/O window passes through
    assign addr32         = 32'(addr_q);
    assign mem_hit        = addr32 <= 32'(MEM_END_WORD_ADDR);
    assign avalon_address = mem_hit ? (addr32 * 32'(BYTE_PER_WORD)) : addr32;

    assign avalon_writedata  = 32'(dout_q);
    assign avalon_byteenable = BE_MASK[3:0];
    assign avalon_read       = (state == RD);
    assign avalon_write      = (state == WR);
    assign Busy              = (state != IDLE);
    assign Done              = (state == DONE);
    assign state_dbg         = state;

endmodule

// File: tb/tb_avalon_bridge.sv
// tb_avalon_bridge: scoreboard bench for avalon_bridge (DATA_W=16, ADDR_W=16).
// Expected DIN values are queued at request time and popped at Done.
module tb_avalon_bridge;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req;
    logic        W;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic [15:0] DIN;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic        avalon_wait_request;
    logic [31:0] avalon_readdata;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_address;
    logic [31:0] avalon_writedata;
    logic [3:0]  avalon_byteenable;
    logic [1:0]  state_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_din;

    avalon_bridge #(
        .DATA_W(16), .ADDR_W(16), .MEM_END_WORD_ADDR(16'h80),
        .BYTE_PER_WORD(4), .TIMEOUT_CYC(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .W(W), .ADDR(ADDR),
        .DOUT(DOUT), .DIN(DIN), .Busy(Busy), .Done(Done), .Err(Err),
        .avalon_wait_request(avalon_wait_request),
        .avalon_readdata(avalon_readdata),
        .avalon_read(avalon_read), .avalon_write(avalon_write),
        .avalon_address(avalon_address), .avalon_writedata(avalon_writedata),
        .avalon_byteenable(avalon_byteenable), .state_dbg(state_dbg)
    );

    // Clock
    always #5 Clock = ~Clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [31:0] ref_addr(input logic [15:0] a);
        if (a <= 16'h0080) return {16'h0, a} << 2;
        else               return {16'h0, a};
    endfunction

    // Full transaction: Req in cycle 0, 'waits' wait-state cycles, Done, back to IDLE
    task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic req_in_done);
        int          held;
        logic [15:0] exp_din;
        logic [15:0] rlow;
        rlow = rdata[15:0];
        exp_q.push_back(w ? model_din : rlow);
        if (!w) model_din = rlow;
        Req = 1'b1; W = w; ADDR = a; DOUT = d;
        avalon_readdata = rdata;
        avalon_wait_request = (waits > 0);
        tick();
        Req = 1'b0; ADDR = 16'hFFFF; DOUT = 16'hFFFF;
        check("busy_xfer", {31'h0, Busy}, 32'h1);
        held = 0;
        for (int k = 0; k <= waits; k++) begin
            avalon_wait_request = (k < waits);
            if (w ? avalon_write : avalon_read) held++;
            check("rw_excl", {31'h0, avalon_read & avalon_write}, 32'h0);
            check("addr", avalon_address, exp_addr);
            check("wdata", avalon_writedata, {16'h0, d});
            check("byteen", {28'h0, avalon_byteenable}, 32'h3);
            check("done_early", {31'h0, Done}, 32'h0);
            tick();
        end
        check("held_cycles", 32'(held), 32'(waits + 1));
        check("done", {31'h0, Done}, 32'h1);
        check("err_clear", {31'h0, Err}, 32'h0);
        check("rw_in_done", {30'h0, avalon_read, avalon_write}, 32'h0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'h0, 32'h1);
        end else begin
            exp_din = exp_q.pop_front();
            check("din", {16'h0, DIN}, {16'h0, exp_din});
        end
        if (req_in_done) begin
            Req = 1'b1; W = 1'b0;
        end
        tick();
        Req = 1'b0;
        check("done_pulse", {31'h0, Done}, 32'h0);
        check("idle", {31'h0, Busy}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; W = 1'b0; ADDR = '0; DOUT = '0;
        avalon_wait_request = 1'b0; avalon_readdata = '0;
        model_din = 16'h0;
        tick(); tick();
        Reset = 1'b0;
        check("rst_din", {16'h0, DIN}, 32'h0);
        check("rst_busy", {31'h0, Busy}, 32'h0);
        check("rst_done", {31'h0, Done}, 32'h0);
        check("rst_err", {31'h0, Err}, 32'h0);
        check("rst_rw", {30'h0, avalon_read, avalon_write}, 32'h0);
        tick();
        check("idle_hold", {31'h0, Busy}, 32'h0);

        // Directed: read zero wait, write with 3 waits, address boundary
        do_txn(1'b0, 16'h0010, 16'h0000, 0, 32'hABCD1234, 32'h40, 1'b0);
        do_txn(1'b1, 16'h1000, 16'h5A5A, 3, 32'hDEAD0000, 32'h1000, 1'b0);
        do_txn(1'b0, 16'h0080, 16'h0000, 1, 32'h0000BEEF, 32'h200, 1'b1);
        do_txn(1'b1, 16'h0081, 16'hC3C3, 0, 32'h0, 32'h81, 1'b0);
        do_txn(1'b0, 16'h0000, 16'h0000, 2, 32'h12345678, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 10; i++) begin
            logic [15:0] ra;
            logic        rw;
            ra = 16'($urandom_range(0, 16'h0100));
            if (i % 3 == 0) ra = 16'($urandom_range(0, 16'hFFFF));
            rw = 1'($urandom_range(0, 1));
            do_txn(rw, ra, 16'($urandom_range(0, 16'hFFFF)), $urandom_range(0, 3),
                   $urandom, ref_addr(ra), 1'b0);
        end

`ifdef AVALON_BRIDGE_TIMEOUT_EN
        // Read with wait_request stuck high aborts after 4 wait cycles
        Req = 1'b1; W = 1'b0; ADDR = 16'h0020; avalon_wait_request = 1'b1;
        avalon_readdata = 32'h0000FFFF;
        tick();
        Req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("to_no_done", {31'h0, Done}, 32'h0);
            tick();
        end
        check("to_done", {31'h0, Done}, 32'h1);
        check("to_err", {31'h0, Err}, 32'h1);
        check("to_din", {16'h0, DIN}, {16'h0, model_din});
        tick();
        avalon_wait_request = 1'b0;
        check("to_err_hold", {31'h0, Err}, 32'h1);
        do_txn(1'b1, 16'h0030, 16'h1111, 0, 32'h0, 32'hC0, 1'b0);
`else
        check("err_tied", {31'h0, Err}, 32'h0);
`endif

        // Reset during a read stuck in wait
        check("pre_rst_din", {31'h0, DIN != 16'h0}, {31'h0, model_din != 16'h0});
        Req = 1'b1; W = 1'b0; ADDR = 16'h0011; avalon_wait_request = 1'b1;
        tick();
        Req = 1'b0;
        check("mid_read", {31'h0, avalon_read}, 32'h1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mrst_read", {31'h0, avalon_read}, 32'h0);
        check("mrst_busy", {31'h0, Busy}, 32'h0);
        check("mrst_done", {31'h0, Done}, 32'h0);
        check("mrst_din", {16'h0, DIN}, 32'h0);
        model_din = 16'h0;
        for (int k = 0; k < 3; k++) begin
            check("mrst_no_done", {31'h0, Done}, 32'h0);
            tick();
        end
        avalon_wait_request = 1'b0;
        do_txn(1'b0, 16'h0005, 16'h0, 0, 32'h00007777, 32'h14, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
